// File: rtl/move_input.sv
// Switch-to-move-command front end: two-flop sync, per-switch debounce, press arming,
// priority encode, and a small command FIFO with valid/ready output and RESET flush.
module move_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int QUEUE_DEPTH     = 4,
  parameter int CNT_W           = 20
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [15:0]                        SW,
  input  logic                               move_ready,
  output logic [2:0]                         move,
  output logic                               move_valid,
  output logic                               overflow,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level
);

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    RIGHT = 3'd1,
    LEFT  = 3'd2,
    DOWN  = 3'd3,
    UP    = 3'd4,
    RESET = 3'd5
  } move_code_e;

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int LW = $clog2(QUEUE_DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: [0..3] = SW[0..3], [4] = SW[15]
  logic [4:0]       sw_used;
  logic [4:0]       sync1, sync2, stable;
  logic [CNT_W-1:0] cnt [5];
  logic             any_on, any_on_d, gen;
  move_code_e       code;

  logic unused_sw;
  assign unused_sw = ^SW[14:4];

  assign sw_used = {SW[15], SW[3:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= sw_used;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign any_on = |stable;
  assign gen    = any_on & ~any_on_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) any_on_d <= 1'b0;
    else       any_on_d <= any_on;
  end

  always_comb begin
    code = NONE;
    if      (stable[0]) code = RIGHT;
    else if (stable[1]) code = LEFT;
    else if (stable[2]) code = DOWN;
    else if (stable[3]) code = UP;
    else if (stable[4]) code = RESET;
  end

  move_code_e      mem [QUEUE_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic            full, pop, flush, push_ok, wr_en;

  assign full    = (level == LW'(QUEUE_DEPTH));
  assign pop     = move_valid & move_ready;
  assign flush   = gen & (code == RESET);
  assign push_ok = gen & (code != RESET) & (~full | pop);
  assign wr_en   = flush | push_ok;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= code;
  end

  // Flush writes RESET at wr_ptr and moves the read pointer onto it, leaving it as the only entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (flush) begin
        rd_ptr <= wr_ptr;
        wr_ptr <= wr_ptr + PW'(1);
        level  <= LW'(1);
      end else begin
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (gen && full && !pop) overflow <= 1'b1;
        level <= level + LW'(push_ok) - LW'(pop);
      end
    end
  end

  assign move_valid  = (level != '0);
  assign move        = move_valid ? mem[rd_ptr] : NONE;
  assign queue_level = level;

endmodule

// File: tb/tb_move_input.sv
// Bench for move_input: directed vector table, hand-written corner sequences, and random
// stimulus compared every cycle against a queue-based reference model.
module tb_move_input;

  localparam int D  = 4;
  localparam int QD = 4;

  localparam int C_NONE = 0, C_RIGHT = 1, C_LEFT = 2, C_DOWN = 3, C_UP = 4, C_RESET = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] SW;
  logic        move_ready;
  logic [2:0]  move;
  logic        move_valid;
  logic        overflow;
  logic [2:0]  queue_level;

  int checks   = 0;
  int failures = 0;

  move_input #(
    .DEBOUNCE_CYCLES(D),
    .QUEUE_DEPTH(QD),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .SW(SW),
    .move_ready(move_ready),
    .move(move),
    .move_valid(move_valid),
    .overflow(overflow),
    .queue_level(queue_level)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [4:0] m_s1, m_s2, m_stable;
  bit         m_armd;
  bit         m_ovf;
  int         m_q[$];
  logic [4:0] m_hist[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prio(input logic [4:0] s);
    if (s[0]) return C_RIGHT;
    if (s[1]) return C_LEFT;
    if (s[2]) return C_DOWN;
    if (s[3]) return C_UP;
    if (s[4]) return C_RESET;
    return C_NONE;
  endfunction

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    m_armd = 0; m_ovf = 0;
    m_q.delete();
    m_hist.delete();
    for (int k = 0; k < D; k++) m_hist.push_back(5'b0);
  endtask

  task automatic model_edge();
    bit pop, gen;
    int code;
    logic [4:0] used;
    if (!rstn) begin
      model_clear();
      return;
    end
    used = {SW[15], SW[3:0]};
    pop  = (m_q.size() > 0) && move_ready;
    gen  = (m_stable != 0) && !m_armd;
    code = prio(m_stable);
    m_ovf = 0;
    if (gen && code == C_RESET) begin
      m_q.delete();
      m_q.push_back(C_RESET);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (gen) begin
        if (m_q.size() < QD) m_q.push_back(code);
        else m_ovf = 1;
      end
    end
    m_armd = (m_stable != 0);
    // A bit flips once the last D synchronized samples all disagree with it
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    for (int b = 0; b < 5; b++) begin
      bit all_diff = 1;
      for (int k = 0; k < m_hist.size(); k++)
        if (m_hist[k][b] == m_stable[b]) all_diff = 0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    m_s2 = m_s1;
    m_s1 = used;
  endtask

  task automatic compare_model();
    check("model_move",  int'(move),        (m_q.size() > 0) ? m_q[0] : C_NONE);
    check("model_valid", int'(move_valid),  (m_q.size() > 0) ? 1 : 0);
    check("model_ovf",   int'(overflow),    int'(m_ovf));
    check("model_level", int'(queue_level), m_q.size());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_move"},  int'(move),        C_NONE);
    check({tag, "_valid"}, int'(move_valid),  0);
    check({tag, "_ovf"},   int'(overflow),    0);
    check({tag, "_level"}, int'(queue_level), 0);
  endtask

  task automatic press_wait(input logic [15:0] pattern);
    SW = pattern;
    repeat (D + 3) tick();
  endtask

  task automatic release_wait();
    SW = '0;
    repeat (10) tick();
  endtask

  typedef struct {
    logic [15:0] sw;
    int          exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{16'h0001, C_RIGHT};
    vecs[1]  = '{16'h0002, C_LEFT};
    vecs[2]  = '{16'h0004, C_DOWN};
    vecs[3]  = '{16'h0008, C_UP};
    vecs[4]  = '{16'h8000, C_RESET};
    vecs[5]  = '{16'h0003, C_RIGHT};
    vecs[6]  = '{16'h000E, C_LEFT};
    vecs[7]  = '{16'h800C, C_DOWN};
    vecs[8]  = '{16'h8008, C_UP};
    vecs[9]  = '{16'h7FF0, C_NONE};
    vecs[10] = '{16'h0010, C_NONE};

    SW = '0;
    move_ready = 1'b1;
    rstn = 1'b0;
    model_clear();
    repeat (3) tick();
    check_idle("reset");
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle("post_reset");
    end

    // Vector table: latency of D+3 edges, single-cycle pulse with ready high
    foreach (vecs[i]) begin
      SW = vecs[i].sw;
      for (int t = 1; t <= D + 3; t++) begin
        tick();
        check("vec_valid", int'(move_valid), (t == D + 3 && vecs[i].exp != C_NONE) ? 1 : 0);
        check("vec_move", int'(move), (t == D + 3) ? vecs[i].exp : C_NONE);
      end
      tick();
      check("vec_after_move", int'(move), C_NONE);
      check("vec_after_valid", int'(move_valid), 0);
      release_wait();
    end

    // Glitch shorter than the debounce time
    SW = 16'h0002;
    repeat (D - 1) begin
      tick();
      check("glitch_valid", int'(move_valid), 0);
    end
    SW = '0;
    repeat (10) begin
      tick();
      check("glitch_valid", int'(move_valid), 0);
    end

    // Arming: second switch while another is held makes nothing
    press_wait(16'h0003);
    check("arm_first", int'(move), C_RIGHT);
    SW = 16'h0007;
    repeat (12) begin
      tick();
      check("arm_blocked", int'(move_valid), 0);
    end
    release_wait();
    press_wait(16'h0004);
    check("arm_rearmed", int'(move), C_DOWN);
    release_wait();

    // Fill and overflow with ready low, then drain
    move_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      press_wait(16'h0008);
      check("fill_level", int'(queue_level), (i < QD) ? i : QD);
      check("fill_ovf", int'(overflow), (i == 5) ? 1 : 0);
      release_wait();
    end
    move_ready = 1'b1;
    for (int i = 0; i < QD; i++) begin
      check("drain_move", int'(move), C_UP);
      check("drain_level", int'(queue_level), QD - i);
      tick();
    end
    check("drain_empty_move", int'(move), C_NONE);
    check("drain_empty_level", int'(queue_level), 0);

    // RESET flushes pending entries
    move_ready = 1'b0;
    repeat (3) begin
      press_wait(16'h0002);
      release_wait();
    end
    check("flush_pre_level", int'(queue_level), 3);
    press_wait(16'h8000);
    check("flush_level", int'(queue_level), 1);
    check("flush_move", int'(move), C_RESET);
    check("flush_ovf", int'(overflow), 0);
    release_wait();
    repeat (2) begin
      press_wait(16'h0002);
      release_wait();
    end
    check("refill_level", int'(queue_level), 3);
    move_ready = 1'b1;
    tick();
    check("middrain_level", int'(queue_level), 2);
    check("middrain_move", int'(move), C_LEFT);
    rstn = 1'b0;
    #1;
    check_idle("async_reset");
    model_clear();
    repeat (3) tick();
    rstn = 1'b1;
    repeat (4) tick();

    // Random stimulus against the reference model
    begin
      int hold = 0;
      int ready_pct;
      for (int cyc = 0; cyc < 6000; cyc++) begin
        ready_pct = ((cyc / 1000) % 2 == 0) ? 25 : 80;
        if (hold == 0) begin
          case ($urandom_range(0, 4))
            0, 1: SW = '0;
            2: begin
              logic [4:0] one;
              one = 5'b1 << $urandom_range(0, 4);
              SW = {one[4], 11'($urandom), one[3:0]};
            end
            default: SW = 16'($urandom);
          endcase
          hold = $urandom_range(1, 14);
        end
        hold--;
        move_ready = ($urandom_range(0, 99) < ready_pct);
        if ($urandom_range(0, 599) == 0) rstn = 1'b0;
        else rstn = 1'b1;
        tick();
      end
    end

    rstn = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_input.md
Name: move_input

Overview:
- Conditions the 16 board switches into discrete move commands for the game logic stage, which consumes a 3-bit move code.
- Per-switch debounce, press-edge detection with the existing "all switches released" arming rule, and priority encoding.
- Buffers commands in a small FIFO with a valid/ready handshake, so no presses are lost while the logic stage is busy.
- Sits between the top-level SW pins and LOGIC.move.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized switch must differ from its stable value before the stable value flips (10 ms at 100 MHz); must be ≥1.
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock (100 MHz)
- rstn  input  1  asynchronous active-low reset
- SW  input  16  raw board switches, asynchronous
- move_ready  input  1  consumer accepts the head command this cycle
- move  output  3  head command code; NONE when queue empty
- move_valid  output  1  queue non-empty
- overflow  output  1  one-cycle pulse: command dropped, queue full
- queue_level  output  $clog2(QUEUE_DEPTH+1)  entries currently queued

Behaviour:
- Codes come from the PARAMS.v macros NONE, RIGHT, LEFT, DOWN, UP, RESET. Only SW[0..3] and SW[15] are used; the other bits are ignored.
- Reset (rstn low, async):
  - sync flops, stable states and counters clear to 0;
  - queue empties;
  - outputs go to move=NONE, move_valid=0, overflow=0, queue_level=0.
  - Switches held through reset release are treated as new presses after the debounce time.
- Synchronizer: each used bit passes through 2 flops.
- Debounce, per bit:
  - counter clears whenever sync == stable;
  - otherwise it increments;
  - on the cycle the counter would reach DEBOUNCE_CYCLES, stable takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Arming:
  - any_on = OR of stable bits; any_on_d = any_on delayed 1 cycle.
  - A command is generated only on the cycle any_on=1 and any_on_d=0.
  - Further presses while any switch is still stably on generate nothing.
- Priority at generation: SW0→RIGHT, else SW1→LEFT, else SW2→DOWN, else SW3→UP, else SW15→RESET. Only stable bits are examined.
- Enqueue happens at the edge after generation.
- Latency: SW change to move_valid=1 (queue previously empty) is DEBOUNCE_CYCLES+3 clk edges.
- Handshake:
  - a pop occurs when move_valid && move_ready;
  - move and move_valid change only at the edge after the pop or push;
  - move always shows the head entry combinationally from storage.
  - With move_ready tied high, each command appears as a single-cycle move pulse, then NONE.
- RESET command flushes the queue: all pending entries are discarded and RESET becomes the sole entry, queue_level=1. This applies even when the queue is full; RESET never sets overflow.
- Full queue:
  - a non-RESET push with no simultaneous pop is dropped, and overflow pulses for 1 cycle;
  - push plus pop on the same cycle while full is accepted, level unchanged, no overflow.
- Empty queue:
  - a pop is impossible (move_valid=0), and move_ready is ignored;
  - push plus move_ready on the same cycle only pushes; no bypass.
- Pointers wrap modulo QUEUE_DEPTH. queue_level ranges 0..QUEUE_DEPTH.

Test Plan (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4, move_ready=1 unless stated):
- Reset release with SW=0: move=NONE, move_valid=0, queue_level=0, overflow=0 on every cycle; all outputs hold their values.
- SW[0] 0→1 held: move_valid=1 with move=RIGHT exactly 7 edges after the change, for 1 cycle; then move=NONE.
- SW[1] pulses high for 3 cycles then low: no command, move_valid stays 0.
- SW=0x0003 rising together: a single RIGHT command. SW[2] then rising while SW[0] still held: no command. All released, then SW[2] rising: DOWN.
- move_ready=0, five separate UP presses (each released ≥6 cycles):
  - queue_level reaches 4;
  - overflow pulses once, on the 5th;
  - raising move_ready then drains 4 UP, one per cycle.
- Queue holding 3 LEFT with move_ready=0, then SW[15] press: queue_level=1, move=RESET, overflow=0. Next, rstn pulled low mid-drain: all outputs return to reset values immediately.
